alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
Multicycle control FSM that sequences the shared ALU and its operand muxes. It drives the source-A select, the 2-bit source-B select and the ALU function code, plus the PC, IR, memory and register-file strobes. It decodes a MIPS subset from the opcode/funct fields of the instruction register and sits between the instruction register and the datapath muxes.

Parameters:
MEM_WAIT, 1, extra wait cycles per memory access (legal range 0..15; 4-bit counter).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, same cycle
AluSrcA  output  1  0 = PC, 1 = register A
AluSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
AluOp  output  3  000 = none, 001 = add, 010 = sub, 011 = and, 100 = or, 101 = slt
pc_load  output  1  PCWrite | (PCWriteCond & zero)
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
IorD  output  1  0 = PC address, 1 = ALUOut address
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegWrite  output  1  register file write
RegDst  output  1  0 = rt, 1 = rd
MemToReg  output  1  0 = ALUOut, 1 = MDR
trap  output  1  unsupported instruction seen
state_out  output  4  current state encoding, for debug

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register and wait counter; pc_load also depends on zero. Any output not listed for a state is 0.
- reset high at an edge forces state RESET(0) and wait counter 0, including mid-instruction. In RESET all outputs are 0. RESET always goes to FETCH on the next edge.
- Wait counter cnt (4 bits) clears on entry to every state and increments each cycle while waiting.
- FETCH(1): AluSrcA=0, AluSrcB=01, AluOp=001, IorD=0.
  - If cnt != MEM_WAIT: stay.
  - If cnt == MEM_WAIT: IRWrite=1, PCWrite=1, PCSource=00, go to DECODE.
  - With MEM_WAIT=0, FETCH lasts exactly 1 cycle.
- DECODE(2): AluSrcA=0, AluSrcB=11, AluOp=001 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R, if funct is one of 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; otherwise TRAP.
  - 0x08 → EXEC_I.
  - 0x23 or 0x2B → ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - any other opcode → TRAP.
- EXEC_R(3): AluSrcA=1, AluSrcB=00, AluOp from funct (add 001, sub 010, and 011, or 100, slt 101). Next: WB_R.
- WB_R(4): RegWrite=1, RegDst=1, MemToReg=0. Next: FETCH.
- EXEC_I(5): AluSrcA=1, AluSrcB=10, AluOp=001. Next: WB_I.
- WB_I(6): RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
- ADDR(7): AluSrcA=1, AluSrcB=10, AluOp=001. Next: MEM_RD for opcode 0x23, MEM_WR for opcode 0x2B. The opcode must be stable, since the IR is not written outside FETCH.
- MEM_RD(8): IorD=1. Go to MEM_WB when cnt == MEM_WAIT.
- MEM_WB(9): RegWrite=1, RegDst=0, MemToReg=1. Next: FETCH.
- MEM_WR(10): IorD=1, MemWrite=1 every cycle in the state (MEM_WAIT+1 cycles total). Go to FETCH when cnt == MEM_WAIT.
- BRANCH(11): AluSrcA=1, AluSrcB=00, AluOp=010, PCWriteCond=1, PCSource=01, so pc_load=zero. Next: FETCH.
- JUMP(12): PCWrite=1, PCSource=10. Next: FETCH.
- TRAP(13): trap=1, everything else 0. Held until reset.
- Encodings 14 and 15 are unreachable and go to RESET.
- Latency per instruction, with W = MEM_WAIT:
  - R-type, addi: 4+W cycles.
  - lw: 5+2W cycles.
  - sw: 4+2W cycles.
  - beq, j: 3+W cycles.

Test Plan:
- Reset asserted 3 cycles mid-EXEC_R → state_out=0 and all outputs 0 the cycle after; FETCH the next cycle; with MEM_WAIT=1, IRWrite=1 and pc_load=1 on the 2nd FETCH cycle.
- R-type add (opcode 0x00, funct 0x20), MEM_WAIT=1 → sequence FETCH,FETCH,DECODE,EXEC_R,WB_R. EXEC_R drives AluSrcA=1, AluSrcB=00, AluOp=001. WB_R drives RegWrite=1, RegDst=1.
- lw (0x23), MEM_WAIT=2 → ADDR drives AluSrcB=10. MEM_RD lasts 3 cycles with IorD=1. MEM_WB drives MemToReg=1. Total 9 cycles.
- sw (0x2B), MEM_WAIT=0 → MemWrite=1 for exactly 1 cycle; RegWrite never 1; next state FETCH.
- beq (0x04) twice → with zero=1, pc_load=1 and PCSource=01 in BRANCH; with zero=0, pc_load=0. DECODE drives AluSrcB=11 in both runs.
- opcode 0x3F, and separately opcode 0x00 with funct 0x07 → TRAP, trap=1 held 10 cycles with no strobes; reset returns the FSM to FETCH.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multicycle control FSM for a shared-ALU MIPS-subset datapath.
// Sequences ALU operand muxes, function code, PC/IR/memory/register-file strobes.
module alu_seq_ctrl #(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic [2:0] AluOp,
   output logic       pc_load,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       trap,
   output logic [3:0] state_out
);

   localparam logic [3:0] S_RESET  = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_EXEC_R = 4'd3;
   localparam logic [3:0] S_WB_R   = 4'd4;
   localparam logic [3:0] S_EXEC_I = 4'd5;
   localparam logic [3:0] S_WB_I   = 4'd6;
   localparam logic [3:0] S_ADDR   = 4'd7;
   localparam logic [3:0] S_MEM_RD = 4'd8;
   localparam logic [3:0] S_MEM_WB = 4'd9;
   localparam logic [3:0] S_MEM_WR = 4'd10;
   localparam logic [3:0] S_BRANCH = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;
   localparam logic [3:0] S_TRAP   = 4'd13;

   localparam logic [2:0] ALU_NONE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;

   localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

   logic [3:0] r_state;
   logic [3:0] r_cnt;
   logic [3:0] w_next;
   logic       w_wait_done;
   logic       w_waiting;
   logic       w_funct_ok;
   logic       w_pc_write;
   logic       w_pc_cond;

   // R-type funct decode; unsupported functs map to ALU_NONE and trap in DECODE
   function automatic logic [2:0] f_alu_fn(input logic [5:0] f);
      case (f)
         6'h20:   return ALU_ADD;
         6'h22:   return ALU_SUB;
         6'h24:   return ALU_AND;
         6'h25:   return ALU_OR;
         6'h2A:   return ALU_SLT;
         default: return ALU_NONE;
      endcase
   endfunction

   assign w_wait_done = (r_cnt == LP_WAIT);
   assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign w_funct_ok  = (f_alu_fn(funct) != ALU_NONE);
   assign pc_load     = w_pc_write | (w_pc_cond & zero);
   assign state_out   = r_state;

   // Counter restarts from zero whenever the state changes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RESET;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next == r_state && w_waiting) ? r_cnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      w_next = S_RESET;
      case (r_state)
         S_RESET:  w_next = S_FETCH;
         S_FETCH:  w_next = w_wait_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               6'h00:        w_next = w_funct_ok ? S_EXEC_R : S_TRAP;
               6'h08:        w_next = S_EXEC_I;
               6'h23, 6'h2B: w_next = S_ADDR;
               6'h04:        w_next = S_BRANCH;
               6'h02:        w_next = S_JUMP;
               default:      w_next = S_TRAP;
            endcase
         end
         S_EXEC_R: w_next = S_WB_R;
         S_WB_R:   w_next = S_FETCH;
         S_EXEC_I: w_next = S_WB_I;
         S_WB_I:   w_next = S_FETCH;
         S_ADDR:   w_next = (opcode == 6'h2B) ? S_MEM_WR :
                            (opcode == 6'h23) ? S_MEM_RD : S_TRAP;
         S_MEM_RD: w_next = w_wait_done ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB: w_next = S_FETCH;
         S_MEM_WR: w_next = w_wait_done ? S_FETCH : S_MEM_WR;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_RESET;
      endcase
   end

   always_comb begin
      AluSrcA    = 1'b0;
      AluSrcB    = 2'b00;
      AluOp      = ALU_NONE;
      PCSource   = 2'b00;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      trap       = 1'b0;
      w_pc_write = 1'b0;
      w_pc_cond  = 1'b0;
      case (r_state)
         S_FETCH: begin
            AluSrcB = 2'b01;
            AluOp   = ALU_ADD;
            if (w_wait_done) begin
               IRWrite    = 1'b1;
               w_pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            AluSrcB = 2'b11;
            AluOp   = ALU_ADD;
         end
         S_EXEC_R: begin
            AluSrcA = 1'b1;
            AluOp   = f_alu_fn(funct);
         end
         S_WB_R: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_EXEC_I, S_ADDR: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
            AluOp   = ALU_ADD;
         end
         S_WB_I:   RegWrite = 1'b1;
         S_MEM_RD: IorD = 1'b1;
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            AluSrcA   = 1'b1;
            AluOp     = ALU_SUB;
            w_pc_cond = 1'b1;
            PCSource  = 2'b01;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            PCSource   = 2'b10;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

endmodule
